matrix_addsub_seq: RTL
======================

Name: matrix_addsub_seq

Overview:
Multi-cycle, parametrised element-wise matrix add/subtract unit for the coprocessor's operation bank.
- Supersedes the fixed 8-bit, 5x5, single-cycle combinational adder.
- Adds subtraction, selectable saturate/wrap arithmetic and LANES elements processed per cycle.
- Uses a start/busy/done handshake and reports a per-operation overflow count.
- Sits between the operand registers loaded by the HPS bridge and the result mux of the control unit.

Parameters:
ELEM_W, 8, signed element width in bits (two's complement)
MAX_DIM, 5, largest supported square dimension (minimum 2)
LANES, 5, elements computed per clock (1..MAX_DIM*MAX_DIM)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op_mode  input  2  bit0: 0=A+B, 1=A-B; bit1: 0=saturate, 1=wrap
matrix_size  input  SZ_W=max(1,$clog2(MAX_DIM-1))  dimension code; dimension = code+2 (0=2x2 .. MAX_DIM-2=MAX_DIMxMAX_DIM)
matrix_a  input  MAX_DIM*MAX_DIM*ELEM_W  row-major; element i at [i*ELEM_W +: ELEM_W]
matrix_b  input  MAX_DIM*MAX_DIM*ELEM_W  same packing as matrix_a
result_out  output  MAX_DIM*MAX_DIM*ELEM_W  same packing; inactive elements are 0
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when result_out is complete
overflow  output  1  sticky: any active element overflowed in the last operation
ovf_count  output  $clog2(MAX_DIM*MAX_DIM+1)  number of overflowing active elements

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; result_out, overflow, ovf_count, busy, done all 0; element index idx=0.
  - Overrides every other input, including mid-operation; a partial result is discarded.
- Active element count and compute cycles:
  - N = (matrix_size+2)^2.
  - A code above MAX_DIM-2 clamps to MAX_DIM.
  - C = ceil(N/LANES) compute cycles.
- IDLE:
  - On an edge with start=1, latch matrix_a, matrix_b, op_mode and the clamped size.
  - At the same edge clear result_out, overflow and ovf_count, set idx=0, and go to COMPUTE.
  - Operand inputs may change freely after the capture edge.
- COMPUTE:
  - Each edge processes elements idx..idx+LANES-1; indices >=N or >=MAX_DIM^2 are skipped and stay 0.
  - idx advances by LANES.
  - The edge that processes the last active element moves to DONE.
- DONE:
  - done=1 for exactly one cycle; next edge returns to IDLE.
  - Timing: done is high in the cycle following the C-th edge after the start-capture edge.
- start while busy (COMPUTE or DONE) is ignored; it is not queued.
- result_out, overflow and ovf_count hold their values from DONE until the next accepted start.
- Arithmetic per element:
  - Sign-extend both operands to ELEM_W+1; compute a+b or a-b.
  - Overflow occurs when bits [ELEM_W] and [ELEM_W-1] of the extended result differ.
  - Saturate mode: on overflow, output +2^(ELEM_W-1)-1 if the true result is positive, else -2^(ELEM_W-1).
  - Wrap mode: output the low ELEM_W bits.
  - The overflow flag and count are updated in both modes.
- Counting: ovf_count adds up to LANES per cycle (popcount of lane overflow bits); overflow = (ovf_count != 0), registered.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package/include holds:
  - op_mode bit positions (OP_SUB=0, OP_WRAP=1);
  - state encoding (IDLE, COMPUTE, DONE);
  - the size-code-to-dimension mapping, shared with the other matrix operation blocks.
- One sub-module: matrix_elem_alu.
  - Combinational, ELEM_W parameter.
  - Ports a, b, sub, wrap -> y, ovf.
  - Instantiated LANES times by generate.

Test Plan:
- 2x2 add saturate, A=[1,2,3,4], B=[10,20,30,40], LANES=5 -> done 1 cycle after capture edge; result=[11,22,33,44], other 21 elements 0, overflow=0, ovf_count=0.
- 3x3 add saturate, A[0]=100,B[0]=50; A[4]=-100,B[4]=-50; rest 1+1 -> result[0]=127, result[4]=-128, others 2; overflow=1, ovf_count=2.
- 5x5 subtract, A[24]=-128, B[24]=1: saturate -> result[24]=-128, ovf_count=1; wrap -> result[24]=127, ovf_count=1; done exactly 5 cycles after capture edge with LANES=5.
- Handshake: pulse start again during COMPUTE and during DONE -> ignored, a single done pulse; change matrix_a after capture -> result unaffected.
- Reset mid-operation: assert rst on the 3rd compute cycle of a 5x5 op -> next cycle busy=0, result_out=0, ovf_count=0; a new start then completes normally.
- Parameter sweep ELEM_W=16, MAX_DIM=4, LANES=3, 4x4 all elements 32767+1 saturate -> all 16 results 32767, ovf_count=16, done 6 cycles after capture.

Source files
------------

// File: rtl/matrix_addsub_seq_pkg.sv
// Shared definitions for the matrix operation blocks: op_mode bit positions,
// controller state encoding and the size-code-to-dimension mapping.
package matrix_addsub_seq_pkg;

  // op_mode bit positions
  localparam int OP_SUB  = 0;  // 0: A+B, 1: A-B
  localparam int OP_WRAP = 1;  // 0: saturate, 1: wrap

  // Controller state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  // Dimension code -> square dimension; codes past the largest size clamp to it.
  function automatic int unsigned size_code_to_dim(input int unsigned code,
                                                   input int unsigned max_dim);
    if (code > max_dim - 2) return max_dim;
    else                    return code + 2;
  endfunction

endpackage

// File: rtl/matrix_addsub_seq_elem_alu.sv
// Single-element signed add/subtract with overflow detection and optional
// saturation. Purely combinational; one instance per lane.
module matrix_elem_alu #(
  parameter int ELEM_W = 8
) (
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  input  logic              sub,
  input  logic              wrap,
  output logic [ELEM_W-1:0] y,
  output logic              ovf
);

  localparam logic [ELEM_W-1:0] SAT_MAX = {1'b0, {(ELEM_W-1){1'b1}}};
  localparam logic [ELEM_W-1:0] SAT_MIN = {1'b1, {(ELEM_W-1){1'b0}}};

  logic [ELEM_W:0] ext_a;
  logic [ELEM_W:0] ext_b;
  logic [ELEM_W:0] sum;

  assign ext_a = {a[ELEM_W-1], a};
  assign ext_b = {b[ELEM_W-1], b};

  // Extended-width sum/difference, overflow check and output selection
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    y   = '0;
    sum = sub ? (ext_a - ext_b) : (ext_a + ext_b);
    // The extra bit can never overflow, so it carries the true sign.
    ovf = sum[ELEM_W] ^ sum[ELEM_W-1];
    if (ovf && !wrap) y = sum[ELEM_W] ? SAT_MIN : SAT_MAX;
    else              y = sum[ELEM_W-1:0];
  end

endmodule

// File: rtl/matrix_addsub_seq.sv
// Multi-cycle element-wise matrix add/subtract. Operands are captured on an
// accepted start, then LANES elements are processed per clock until all
// active elements of the (clamped) square matrix are done.
module matrix_addsub_seq
  import matrix_addsub_seq_pkg::*;
#(
  parameter int ELEM_W  = 8,
  parameter int MAX_DIM = 5,
  parameter int LANES   = 5,
  localparam int TOTAL  = MAX_DIM * MAX_DIM,
  localparam int VEC_W  = TOTAL * ELEM_W,
  localparam int SZ_W   = ($clog2(MAX_DIM - 1) > 1) ? $clog2(MAX_DIM - 1) : 1,
  localparam int CNT_W  = $clog2(TOTAL + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op_mode,
  input  logic [SZ_W-1:0]  matrix_size,
  input  logic [VEC_W-1:0] matrix_a,
  input  logic [VEC_W-1:0] matrix_b,
  output logic [VEC_W-1:0] result_out,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] ovf_count
);

  // Wide enough to hold idx + LANES without wrapping.
  localparam int IDX_W = $clog2(TOTAL + LANES + 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] n_active;
  logic [1:0]       mode_q;
  logic [VEC_W-1:0] a_q;
  logic [VEC_W-1:0] b_q;

  logic [IDX_W-1:0]  cap_n;
  logic              accept;
  logic              last_step;

  logic [LANES-1:0]  lane_act;
  logic [IDX_W-1:0]  lane_idx [LANES];
  logic [ELEM_W-1:0] lane_a   [LANES];
  logic [ELEM_W-1:0] lane_b   [LANES];
  logic [ELEM_W-1:0] lane_y   [LANES];
  logic [LANES-1:0]  lane_ovf;

  logic [CNT_W-1:0]  lane_cnt;
  logic [CNT_W-1:0]  cnt_next;

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign accept    = (state == ST_IDLE) && start;
  assign cap_n     = IDX_W'(size_code_to_dim(32'(matrix_size), MAX_DIM) *
                            size_code_to_dim(32'(matrix_size), MAX_DIM));
  assign last_step = ((idx + IDX_W'(LANES)) >= n_active);

  // Per-lane element selection and arithmetic
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IDX_W-1:0] elem;
    assign elem        = idx + IDX_W'(l);
    assign lane_act[l] = (elem < n_active) && (elem < IDX_W'(TOTAL));
    // Inactive lanes point at element 0 so the select never leaves the vector.
    assign lane_idx[l] = lane_act[l] ? elem : '0;
    assign lane_a[l]   = lane_act[l] ? a_q[lane_idx[l]*ELEM_W +: ELEM_W] : '0;
    assign lane_b[l]   = lane_act[l] ? b_q[lane_idx[l]*ELEM_W +: ELEM_W] : '0;

    matrix_elem_alu #(.ELEM_W(ELEM_W)) u_alu (
      .a    (lane_a[l]),
      .b    (lane_b[l]),
      .sub  (mode_q[OP_SUB]),
      .wrap (mode_q[OP_WRAP]),
      .y    (lane_y[l]),
      .ovf  (lane_ovf[l])
    );
  end

  // Popcount of active-lane overflows added to the running count
  always_comb begin
    lane_cnt = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_act[l] && lane_ovf[l]) lane_cnt = lane_cnt + CNT_W'(1);
    end
    cnt_next = ovf_count + lane_cnt;
  end

  // Operand capture on an accepted start
  always_ff @(posedge clk) begin
    // NOTE: operand registers carry no reset; they are always loaded before being read.
    if (!rst && accept) begin
      a_q <= matrix_a;
      b_q <= matrix_b;
    end
  end

  // Controller, result accumulation and overflow bookkeeping
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      n_active   <= '0;
      mode_q     <= '0;
      result_out <= '0;
      overflow   <= 1'b0;
      ovf_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q     <= op_mode;
            n_active   <= cap_n;
            idx        <= '0;
            result_out <= '0;
            overflow   <= 1'b0;
            ovf_count  <= '0;
            state      <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          for (int l = 0; l < LANES; l++) begin
            if (lane_act[l]) result_out[lane_idx[l]*ELEM_W +: ELEM_W] <= lane_y[l];
          end
          ovf_count <= cnt_next;
          overflow  <= (cnt_next != '0);
          idx       <= idx + IDX_W'(LANES);
          if (last_step) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
